// File: rtl/regfile_operand_fetch.sv
// Eight-entry register file with a two-cycle operand-fetch sequencer (ain, then bin).
// Optional build macro RF_BYPASS_EN forwards a same-edge write into the operand being loaded.
module regfile_operand_fetch #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write,
    input  logic [AW-1:0]    writenum,
    input  logic [WIDTH-1:0] data_in,
    input  logic             start,
    input  logic [AW-1:0]    rn,
    input  logic [AW-1:0]    rm,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ain,
    output logic [WIDTH-1:0] bin
);

    localparam int NREG = 2 ** AW;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ_A = 2'd1,
        READ_B = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state_r;
    logic [AW-1:0]    rn_r;
    logic [AW-1:0]    rm_r;
    logic [WIDTH-1:0] ain_r;
    logic [WIDTH-1:0] bin_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] regs_r [NREG];
    logic [WIDTH-1:0] rd_a_s;
    logic [WIDTH-1:0] rd_b_s;

    // Operand read ports, optionally forwarding a write that lands on the same edge
    always_comb begin
        rd_a_s = regs_r[rn_r];
        rd_b_s = regs_r[rm_r];
`ifdef RF_BYPASS_EN
        if (write && (writenum == rn_r)) begin
            rd_a_s = data_in;
        end else begin
            rd_a_s = regs_r[rn_r];
        end
        if (write && (writenum == rm_r)) begin
            rd_b_s = data_in;
        end else begin
            rd_b_s = regs_r[rm_r];
        end
`endif
    end

    // Register file storage; writes are accepted in every state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= '0;
            end
        end else if (write) begin
            regs_r[writenum] <= data_in;
        end
    end

    // Fetch sequencer; busy/done are registered from the next state so they track state exactly
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            rn_r    <= '0;
            rm_r    <= '0;
            ain_r   <= '0;
            bin_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        rn_r    <= rn;
                        rm_r    <= rm;
                        state_r <= READ_A;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end
                end
                READ_A: begin
                    ain_r   <= rd_a_s;
                    state_r <= READ_B;
                    busy_r  <= 1'b1;
                    done_r  <= 1'b0;
                end
                READ_B: begin
                    bin_r   <= rd_b_s;
                    state_r <= DONE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign ain  = ain_r;
    assign bin  = bin_r;

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Directed bench for regfile_operand_fetch; expectations follow RF_BYPASS_EN when defined.
module tb_regfile_operand_fetch;

    localparam int WIDTH = 16;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             write;
    logic [AW-1:0]    writenum;
    logic [WIDTH-1:0] data_in;
    logic             start;
    logic [AW-1:0]    rn;
    logic [AW-1:0]    rm;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] ain;
    logic [WIDTH-1:0] bin;

    int passed = 0;
    int total  = 0;

    regfile_operand_fetch #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .write(write), .writenum(writenum),
        .data_in(data_in), .start(start), .rn(rn), .rm(rm),
        .busy(busy), .done(done), .ain(ain), .bin(bin)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic wr(input logic [AW-1:0] n, input logic [WIDTH-1:0] d);
        write = 1'b1; writenum = n; data_in = d;
        tick();
        write = 1'b0;
    endtask

    // start in cycle 0, then walk cycles 1..4 checking timing and operands
    task automatic fetch(input string tag, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [WIDTH-1:0] ea, input logic [WIDTH-1:0] eb);
        start = 1'b1; rn = a; rm = b;
        tick();
        start = 1'b0;
        check({tag, " c1 busy"}, {15'd0, busy}, 16'd1);
        check({tag, " c1 done"}, {15'd0, done}, 16'd0);
        tick();
        check({tag, " c2 busy"}, {15'd0, busy}, 16'd1);
        check({tag, " c2 ain"}, ain, ea);
        tick();
        check({tag, " c3 done"}, {15'd0, done}, 16'd1);
        check({tag, " c3 busy"}, {15'd0, busy}, 16'd0);
        check({tag, " c3 ain"}, ain, ea);
        check({tag, " c3 bin"}, bin, eb);
        tick();
        check({tag, " c4 done"}, {15'd0, done}, 16'd0);
        check({tag, " c4 ain held"}, ain, ea);
        check({tag, " c4 bin held"}, bin, eb);
    endtask

    initial begin
        logic [WIDTH-1:0] exp_b;
        reset = 1'b1; write = 1'b0; writenum = '0; data_in = '0;
        start = 1'b0; rn = '0; rm = '0;
        #2;
        check("rst busy", {15'd0, busy}, 16'd0);
        check("rst done", {15'd0, done}, 16'd0);
        check("rst ain", ain, 16'h0000);
        check("rst bin", bin, 16'h0000);
        tick();
        tick();
        reset = 1'b0;
        fetch("rst fetch", 3'd3, 3'd7, 16'h0000, 16'h0000);

        wr(3'd2, 16'h1234);
        wr(3'd5, 16'hABCD);
        fetch("basic", 3'd2, 3'd5, 16'h1234, 16'hABCD);

        // start pulsed during READ_A must not be captured
        start = 1'b1; rn = 3'd2; rm = 3'd5;
        tick();
        rn = 3'd0; rm = 3'd0;
        tick();
        start = 1'b0;
        check("ign c2 ain", ain, 16'h1234);
        tick();
        check("ign c3 done", {15'd0, done}, 16'd1);
        check("ign c3 ain", ain, 16'h1234);
        check("ign c3 bin", bin, 16'hABCD);
        tick();
        check("ign c4 done", {15'd0, done}, 16'd0);
        check("ign c4 busy", {15'd0, busy}, 16'd0);
        tick();
        check("ign c5 done", {15'd0, done}, 16'd0);

        // write to R5 on the READ_B edge
        start = 1'b1; rn = 3'd2; rm = 3'd5;
        tick();
        start = 1'b0;
        tick();
        write = 1'b1; writenum = 3'd5; data_in = 16'h0F0F;
        tick();
        write = 1'b0;
`ifdef RF_BYPASS_EN
        exp_b = 16'h0F0F;
`else
        exp_b = 16'hABCD;
`endif
        check("same-edge done", {15'd0, done}, 16'd1);
        check("same-edge bin", bin, exp_b);
        tick();
        fetch("after write", 3'd2, 3'd5, 16'h1234, 16'h0F0F);

        // asynchronous reset between edges while in READ_B
        start = 1'b1; rn = 3'd5; rm = 3'd2;
        tick();
        start = 1'b0;
        tick();
        #2 reset = 1'b1;
        #1;
        check("async busy", {15'd0, busy}, 16'd0);
        check("async done", {15'd0, done}, 16'd0);
        check("async ain", ain, 16'h0000);
        check("async bin", bin, 16'h0000);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("async no done", {15'd0, done}, 16'd0);
        end
        fetch("regs cleared", 3'd2, 3'd5, 16'h0000, 16'h0000);

        // back-to-back fetches with start held high
        wr(3'd1, 16'h1111);
        wr(3'd2, 16'h2222);
        wr(3'd3, 16'h3333);
        wr(3'd4, 16'h4444);
        wr(3'd6, 16'h6666);
        start = 1'b1; rn = 3'd1; rm = 3'd2;
        tick();
        tick();
        tick();
        check("b2b c3 done", {15'd0, done}, 16'd1);
        check("b2b c3 ain", ain, 16'h1111);
        check("b2b c3 bin", bin, 16'h2222);
        rn = 3'd3; rm = 3'd4;
        tick();
        check("b2b c4 done", {15'd0, done}, 16'd0);
        check("b2b c4 busy", {15'd0, busy}, 16'd1);
        tick();
        tick();
        check("b2b c6 done", {15'd0, done}, 16'd1);
        check("b2b c6 ain", ain, 16'h3333);
        check("b2b c6 bin", bin, 16'h4444);
        rn = 3'd6; rm = 3'd1;
        tick();
        tick();
        tick();
        check("b2b c9 done", {15'd0, done}, 16'd1);
        check("b2b c9 ain", ain, 16'h6666);
        check("b2b c9 bin", bin, 16'h1111);
        start = 1'b0;
        tick();
        check("b2b end done", {15'd0, done}, 16'd0);
        check("b2b end busy", {15'd0, busy}, 16'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
